// File: rtl/lzs_decode_parse.sv
// lzs_decode_parse -- LZS bitstream parser (decompressor front end).
// Pops 16-bit words from a FWFT FIFO into a 32-bit left-aligned bit buffer
// and splits the MSB-first stream into literal and match tokens.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ce              clock enable, freezes everything when low
//   fi, src_empty   FIFO head word (bit 15 first) and empty flag
//   src_getn        active-low pop, word on fi consumed this cycle
//   fo_full         downstream full, holds token emission
//   tok_*_o         token strobe/type/literal/offset/length
//   done_o          one-cycle pulse after an end marker
//   err_o           sticky decode error
module lzs_decode_parse #(
  parameter int LEN_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [15:0]          fi,
  input  logic                 src_empty,
  output logic                 src_getn,
  input  logic                 fo_full,
  output logic                 tok_valid_o,
  output logic                 tok_type_o,
  output logic [7:0]           tok_lit_o,
  output logic [10:0]          tok_off_o,
  output logic [LEN_WIDTH-1:0] tok_len_o,
  output logic                 done_o,
  output logic                 err_o
);
  localparam int EW = LEN_WIDTH + 1;

  typedef enum logic [2:0] {
    S_HDR, S_LIT, S_SHORT, S_LONG, S_LEN, S_EXT, S_END, S_ERR
  } state_t;

  state_t               state, nxt;
  logic [31:0]          bbuf, bbuf_d;
  logic [5:0]           cnt, cnt_d, rem;
  logic [3:0]           used;
  logic [10:0]          off_q, off_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [EW-1:0]        ext_sum;
  logic                 emit, set_err, fin, load;

  // Extra top bit of the sum flags a length past the output width.
  assign ext_sum = {1'b0, len_q} + EW'(bbuf[31:28]);

  assign load = ce && !rst && (cnt <= 6'd16) && !src_empty &&
                (state != S_END) && (state != S_ERR);
  assign src_getn = ~load;

  always_comb begin
    nxt     = state;
    used    = 4'd0;
    emit    = 1'b0;
    set_err = 1'b0;
    fin     = 1'b0;
    off_d   = off_q;
    len_d   = len_q;
    case (state)
      S_HDR: if (cnt >= 6'd1) begin
        if (!bbuf[31]) begin
          used = 4'd1;
          nxt  = S_LIT;
        end else if (cnt >= 6'd2) begin
          used = 4'd2;
          nxt  = bbuf[30] ? S_SHORT : S_LONG;
        end
      end
      S_LIT: if (cnt >= 6'd8 && !fo_full) begin
        used = 4'd8;
        emit = 1'b1;
        nxt  = S_HDR;
      end
      S_SHORT: if (cnt >= 6'd7) begin
        used = 4'd7;
        if (bbuf[31:25] == 7'd0) nxt = S_END;
        else begin
          off_d = {4'd0, bbuf[31:25]};
          nxt   = S_LEN;
        end
      end
      S_LONG: if (cnt >= 6'd11) begin
        used = 4'd11;
        if (bbuf[31:21] == 11'd0) begin
          set_err = 1'b1;
          nxt     = S_ERR;
        end else begin
          off_d = bbuf[31:21];
          nxt   = S_LEN;
        end
      end
      S_LEN: if (cnt >= 6'd2) begin
        if (bbuf[31:30] != 2'b11) begin
          if (!fo_full) begin
            used  = 4'd2;
            len_d = LEN_WIDTH'(2) + LEN_WIDTH'(bbuf[31:30]);
            emit  = 1'b1;
            nxt   = S_HDR;
          end
        end else if (cnt >= 6'd4) begin
          if (bbuf[29:28] == 2'b11) begin
            // 1111 never emits, so it proceeds regardless of fo_full
            used  = 4'd4;
            len_d = LEN_WIDTH'(8);
            nxt   = S_EXT;
          end else if (!fo_full) begin
            used  = 4'd4;
            len_d = LEN_WIDTH'(5) + LEN_WIDTH'(bbuf[29:28]);
            emit  = 1'b1;
            nxt   = S_HDR;
          end
        end
      end
      S_EXT: if (cnt >= 6'd4) begin
        if (ext_sum[LEN_WIDTH]) begin
          set_err = 1'b1;
          nxt     = S_ERR;
        end else if (bbuf[31:28] == 4'hf) begin
          used  = 4'd4;
          len_d = ext_sum[LEN_WIDTH-1:0];
        end else if (!fo_full) begin
          used  = 4'd4;
          len_d = ext_sum[LEN_WIDTH-1:0];
          emit  = 1'b1;
          nxt   = S_HDR;
        end
      end
      S_END: begin
        fin = 1'b1;
        nxt = S_HDR;
      end
      default: ;
    endcase

    // Words always arrive in 16-bit units, so cnt[3:0] is the unread tail
    // of the current word; at end of stream that tail is pad and is dropped.
    rem = cnt - {2'd0, used};
    if (fin) begin
      bbuf_d = bbuf << cnt[3:0];
      cnt_d  = {cnt[5:4], 4'd0};
    end else begin
      bbuf_d = (bbuf << used) | (load ? ({fi, 16'd0} >> rem) : 32'd0);
      cnt_d  = rem + (load ? 6'd16 : 6'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HDR;
      bbuf        <= '0;
      cnt         <= '0;
      off_q       <= '0;
      len_q       <= '0;
      tok_valid_o <= 1'b0;
      tok_type_o  <= 1'b0;
      tok_lit_o   <= '0;
      tok_off_o   <= '0;
      tok_len_o   <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else if (ce) begin
      state       <= nxt;
      bbuf        <= bbuf_d;
      cnt         <= cnt_d;
      off_q       <= off_d;
      len_q       <= len_d;
      tok_valid_o <= emit;
      done_o      <= fin;
      if (set_err) err_o <= 1'b1;
      if (emit) begin
        tok_type_o <= (state != S_LIT);
        if (state == S_LIT) tok_lit_o <= bbuf[31:24];
        else begin
          tok_off_o <= off_q;
          tok_len_o <= len_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_lzs_decode_parse.sv
`timescale 1ns/1ps
module tb_lzs_decode_parse;
  localparam int LW = 12;

  typedef struct {
    bit         mt;
    logic [7:0] lit;
    int         off;
    int         len;
  } tok_t;

  logic clk = 1'b0, rst = 1'b1, ce = 1'b1;
  logic [15:0] fi = '0;
  logic src_empty = 1'b1, src_getn, fo_full = 1'b0;
  logic tok_valid_o, tok_type_o, done_o, err_o;
  logic [7:0] tok_lit_o;
  logic [10:0] tok_off_o;
  logic [LW-1:0] tok_len_o;

  logic [15:0] fi5 = '0;
  logic src_empty5 = 1'b1, src_getn5;
  logic tok_valid5, tok_type5, done5, err5;
  logic [7:0] tok_lit5;
  logic [10:0] tok_off5;
  logic [4:0] tok_len5;

  always #5 clk = ~clk;

  lzs_decode_parse #(.LEN_WIDTH(LW)) u_dut (
    .clk(clk), .rst(rst), .ce(ce), .fi(fi), .src_empty(src_empty),
    .src_getn(src_getn), .fo_full(fo_full), .tok_valid_o(tok_valid_o),
    .tok_type_o(tok_type_o), .tok_lit_o(tok_lit_o), .tok_off_o(tok_off_o),
    .tok_len_o(tok_len_o), .done_o(done_o), .err_o(err_o));

  lzs_decode_parse #(.LEN_WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .ce(ce), .fi(fi5), .src_empty(src_empty5),
    .src_getn(src_getn5), .fo_full(1'b0), .tok_valid_o(tok_valid5),
    .tok_type_o(tok_type5), .tok_lit_o(tok_lit5), .tok_off_o(tok_off5),
    .tok_len_o(tok_len5), .done_o(done5), .err_o(err5));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- FIFO models ----------------
  logic [15:0] fifo[$], fifo5[$];
  int  pops = 0, seen = 0, pops5 = 0;
  bit  starve = 0, bp_rand = 0, fo_hold = 0;
  logic prev_full = 1'b0;

  always @(negedge clk) begin
    fo_full = fo_hold | (bp_rand && $urandom_range(2) == 0);
    if (fifo.size() == 0 || (starve && pops != seen)) begin
      src_empty = 1'b1;
      fi = 16'($urandom);
    end else begin
      src_empty = 1'b0;
      fi = fifo[0];
    end
    seen = pops;
    if (fifo5.size() == 0) begin
      src_empty5 = 1'b1;
      fi5 = '0;
    end else begin
      src_empty5 = 1'b0;
      fi5 = fifo5[0];
    end
  end

  always @(posedge clk) prev_full <= fo_full;

  always @(posedge clk) begin
    if (!src_getn) begin
      chk("pop_nonempty", src_empty, 0);
      if (fifo.size() != 0) void'(fifo.pop_front());
      pops <= pops + 1;
    end
    if (!src_getn5) begin
      if (fifo5.size() != 0) void'(fifo5.pop_front());
      pops5 <= pops5 + 1;
    end
  end

  // ---------------- token scoreboard ----------------
  tok_t exp_q[$];
  int   marks[$];
  int   dones = 0, toks_seen = 0, dones5 = 0, toks5 = 0;
  tok_t e;

  always @(negedge clk) begin
    if (!rst && tok_valid_o) begin
      toks_seen++;
      chk("tok_bp", prev_full, 0);
      if (exp_q.size() == 0) chk("tok_extra", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("tok_type", tok_type_o, e.mt);
        if (!e.mt) chk("tok_lit", tok_lit_o, e.lit);
        else begin
          chk("tok_off", tok_off_o, e.off);
          chk("tok_len", tok_len_o, e.len);
        end
      end
    end
    if (!rst && done_o) begin
      dones++;
      if (marks.size() == 0) chk("done_spurious", 1, 0);
      else chk("done_order", exp_q.size(), marks.pop_front());
    end
    if (!rst && done5) dones5++;
    if (!rst && tok_valid5) toks5++;
  end

  // ---------------- reference encoder ----------------
  bit          bq[$];
  logic [15:0] pend_words[$];
  tok_t        pend_toks[$];
  int          pend_cnt[$];

  task automatic put_bits(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) bq.push_back(v[i]);
  endtask

  task automatic add_stream(input tok_t ts[$]);
    bq.delete();
    foreach (ts[k]) begin
      if (!ts[k].mt) begin
        put_bits(0, 1);
        put_bits(ts[k].lit, 8);
      end else begin
        if (ts[k].off < 128) begin put_bits(3, 2); put_bits(ts[k].off, 7); end
        else begin put_bits(2, 2); put_bits(ts[k].off, 11); end
        if (ts[k].len <= 4) put_bits(ts[k].len - 2, 2);
        else if (ts[k].len <= 7) put_bits(12 + ts[k].len - 5, 4);
        else begin
          int r = ts[k].len - 8;
          put_bits(15, 4);
          while (r >= 15) begin put_bits(15, 4); r -= 15; end
          put_bits(r, 4);
        end
      end
      pend_toks.push_back(ts[k]);
    end
    put_bits(3, 2);
    put_bits(0, 7);
    while (bq.size() % 16 != 0) bq.push_back(1'b0);
    for (int w = 0; w < bq.size() / 16; w++) begin
      logic [15:0] x;
      for (int b = 0; b < 16; b++) x[15-b] = bq[w*16+b];
      pend_words.push_back(x);
    end
    pend_cnt.push_back(ts.size());
  endtask

  function automatic tok_t mk(input bit mt, input int lit, input int off, input int len);
    tok_t t;
    t.mt = mt; t.lit = 8'(lit); t.off = off; t.len = len;
    return t;
  endfunction

  task automatic rand_stream(input int maxn);
    tok_t ts[$];
    int n = int'($urandom_range(maxn, 1));
    for (int i = 0; i < n; i++) begin
      tok_t t;
      t.mt  = ($urandom_range(1) == 1);
      t.lit = 8'($urandom);
      t.off = ($urandom_range(1) == 1) ? int'($urandom_range(127, 1)) : int'($urandom_range(2047, 1));
      case ($urandom_range(3))
        0:       t.len = int'($urandom_range(4, 2));
        1:       t.len = int'($urandom_range(7, 5));
        2:       t.len = int'($urandom_range(40, 8));
        default: t.len = int'($urandom_range(300, 8));
      endcase
      ts.push_back(t);
    end
    add_stream(ts);
  endtask

  task automatic launch(input int hold);
    int d0 = dones;
    int ns = pend_cnt.size();
    int budget = 6000;
    int t0;
    for (int s = 0; s < ns; s++) begin
      int rest = 0;
      for (int j = s + 1; j < ns; j++) rest += pend_cnt[j];
      marks.push_back(rest);
    end
    foreach (pend_toks[k]) exp_q.push_back(pend_toks[k]);
    if (hold > 0) fo_hold = 1;
    foreach (pend_words[k]) fifo.push_back(pend_words[k]);
    if (hold > 0) begin
      t0 = toks_seen;
      repeat (hold) @(negedge clk);
      chk("bp_hold_quiet", toks_seen - t0, 0);
      fo_hold = 0;
    end
    while (dones - d0 < ns && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (4) @(negedge clk);
    chk("streams_done", dones - d0, ns);
    chk("toks_left", exp_q.size(), 0);
    chk("fifo_drained", fifo.size(), 0);
    pend_toks.delete(); pend_words.delete(); pend_cnt.delete();
    exp_q.delete(); marks.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fifo.delete(); fifo5.delete(); exp_q.delete(); marks.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_getn"}, src_getn, 1);
    chk({tag, "_valid"}, tok_valid_o, 0);
    chk({tag, "_tok"}, {tok_type_o, tok_lit_o, tok_off_o, tok_len_o}, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask

  initial begin
    tok_t q[$];
    int p0;

    // reset state: a word waiting in the FIFO must not be popped under rst
    fifo.push_back(16'h20E0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("rst");
    fifo.delete();
    rst = 1'b0;
    @(negedge clk);

    // literal 0x41 + end marker, raw words
    pend_words.push_back(16'h20E0);
    pend_words.push_back(16'h0000);
    pend_toks.push_back(mk(0, 8'h41, 0, 0));
    pend_cnt.push_back(1);
    p0 = pops;
    launch(0);
    chk("lit_end_pops", pops - p0, 2);

    // short match offset 1 length 2
    q.delete(); q.push_back(mk(0, 8'h41, 0, 0)); q.push_back(mk(1, 0, 1, 2));
    add_stream(q); launch(0);

    // long offset with extended length 8+15+3
    q.delete(); q.push_back(mk(1, 0, 1024, 26));
    add_stream(q); launch(0);

    // backpressure: literal + len 7 match held behind fo_full
    q.delete(); q.push_back(mk(0, 8'h5a, 0, 0)); q.push_back(mk(1, 0, 300, 7));
    add_stream(q); launch(10);

    // FIFO starvation, several streams back to back
    starve = 1;
    for (int s = 0; s < 3; s++) rand_stream(6);
    launch(0);
    starve = 0;

    // random streams, some with random backpressure
    for (int it = 0; it < 16; it++) begin
      bp_rand = (it % 2 == 1);
      starve  = (it % 4 == 3);
      for (int s = 0; s < int'($urandom_range(3, 1)); s++) rand_stream(8);
      launch(0);
    end
    bp_rand = 0; starve = 0;

    // LEN_WIDTH=5: max legal length, then overflow
    q.delete(); q.push_back(mk(1, 0, 5, 31));
    add_stream(q);
    foreach (pend_words[k]) fifo5.push_back(pend_words[k]);
    pend_words.delete(); pend_toks.delete(); pend_cnt.delete();
    repeat (60) @(negedge clk);
    chk("len5_max", tok_len5, 31);
    chk("len5_off", tok_off5, 5);
    chk("len5_type", tok_type5, 1);
    chk("len5_lit", tok_lit5, 0);
    chk("len5_toks", toks5, 1);
    chk("len5_done", dones5, 1);
    chk("len5_noerr", err5, 0);
    q.delete(); q.push_back(mk(1, 0, 5, 38));
    add_stream(q);
    foreach (pend_words[k]) fifo5.push_back(pend_words[k]);
    pend_words.delete(); pend_toks.delete(); pend_cnt.delete();
    repeat (60) @(negedge clk);
    chk("err_ovf5", err5, 1);
    chk("ovf5_toks", toks5, 1);

    // long offset 0 -> sticky error, pops stop
    do_reset();
    fifo.push_back(16'h8000); fifo.push_back(16'h1234); fifo.push_back(16'h5678);
    repeat (20) @(negedge clk);
    chk("err_long0", err_o, 1);
    p0 = pops;
    repeat (10) @(negedge clk);
    chk("err_no_pop", pops - p0, 0);
    chk("err_still", err_o, 1);

    // rst clears everything, next stream decodes
    do_reset();
    @(negedge clk);
    chk_idle("rst2");
    chk("rst2_err5", err5, 0);
    q.delete(); q.push_back(mk(1, 0, 77, 5)); q.push_back(mk(0, 8'hc3, 0, 0));
    add_stream(q); launch(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
